// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, write-back and claim signals between decode/write-back stages and the register file
interface regfile_sb_if #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*WIDTH-1:0] rdata;
  logic [NRD-1:0]       rbusy;
  logic                 we0;
  logic [AW-1:0]        waddr0;
  logic [WIDTH-1:0]     wdata0;
  logic                 we1;
  logic [AW-1:0]        waddr1;
  logic [WIDTH-1:0]     wdata1;
  logic                 claim;
  logic [AW-1:0]        claim_addr;
  logic                 claim_ok;
  logic [DEPTH-1:0]     pending;
  modport master (
    output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, claim, claim_addr,
    input  rdata, rbusy, claim_ok, pending
  );
  modport slave (
    input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, claim, claim_addr,
    output rdata, rbusy, claim_ok, pending
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, dual write-back register file with optional zero register, bypass and pending scoreboard
module regfile_sb #(
  parameter int WIDTH    = 48,
  parameter int DEPTH    = 8,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend, rel, set;
  logic ew0, ew1, grant;
  assign ew0 = bus.we0 && !(ZR && bus.waddr0 == '0);
  assign ew1 = bus.we1 && !(ZR && bus.waddr1 == '0);
  assign bus.claim_ok = !pend[bus.claim_addr] || rel[bus.claim_addr];
  assign grant = bus.claim && bus.claim_ok && !(ZR && bus.claim_addr == '0);
  assign bus.pending = pend;
  always_comb begin
    rel = '0;
    set = '0;
    if (ew0) rel[bus.waddr0] = 1'b1;
    if (ew1) rel[bus.waddr1] = 1'b1;
    if (grant) set[bus.claim_addr] = 1'b1;
  end
  // a new claim supersedes a same-cycle release of the same register
  always_ff @(posedge clk or posedge rst)
    if (rst) pend <= '0;
    else pend <= (pend & ~rel) | set;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (ew1 && bus.waddr1 == AW'(i)) regs[i] <= bus.wdata1;
        else if (ew0 && bus.waddr0 == AW'(i)) regs[i] <= bus.wdata0;
    end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.raddr[k*AW +: AW];
    assign bus.rdata[k*WIDTH +: WIDTH] =
      (ZR && a == '0)              ? '0 :
      (BP && ew1 && bus.waddr1 == a) ? bus.wdata1 :
      (BP && ew0 && bus.waddr0 == a) ? bus.wdata0 :
                                       regs[a];
    assign bus.rbusy[k] = pend[a] && !rel[a];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of reads, writes, bypass and scoreboard on bypass and no-bypass instances
module tb_regfile_sb;
  logic clk = 0;
  logic rst = 1;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  regfile_sb_if #(.WIDTH(48), .DEPTH(8), .NRD(2)) ia ();
  regfile_sb_if #(.WIDTH(48), .DEPTH(8), .NRD(2)) ib ();
  regfile_sb #(.WIDTH(48), .DEPTH(8), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  regfile_sb #(.WIDTH(48), .DEPTH(8), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ia.we0 = 0; ia.waddr0 = 0; ia.wdata0 = 0;
    ia.we1 = 0; ia.waddr1 = 0; ia.wdata1 = 0;
    ia.claim = 0; ia.claim_addr = 0;
    ib.we0 = 0; ib.waddr0 = 0; ib.wdata0 = 0;
    ib.we1 = 0; ib.waddr1 = 0; ib.wdata1 = 0;
    ib.claim = 0; ib.claim_addr = 0;
  endtask

  task automatic test_reset();
    idle();
    ia.raddr = {3'd7, 3'd1};
    ib.raddr = {3'd7, 3'd1};
    #1;
    nvec++; if (ia.pending !== 8'h00) begin nerr++; $display("FAIL reset_pending: got %h expected 00", ia.pending); end
    nvec++; if (ia.rbusy !== 2'b00) begin nerr++; $display("FAIL reset_rbusy: got %b expected 00", ia.rbusy); end
    nvec++; if (ia.claim_ok !== 1'b1) begin nerr++; $display("FAIL reset_claim_ok: got %b expected 1", ia.claim_ok); end
    nvec++; if (ia.rdata !== 96'h0) begin nerr++; $display("FAIL reset_rdata: got %h expected 0", ia.rdata); end
    step();
    rst = 0;
  endtask

  task automatic test_zero_reg();
    ia.we0 = 1; ia.waddr0 = 3'd0; ia.wdata0 = 48'h1234;
    ia.raddr = {3'd5, 3'd0};
    #1;
    nvec++; if (ia.rdata[47:0] !== 48'h0) begin nerr++; $display("FAIL zero_bypass: got %h expected 0", ia.rdata[47:0]); end
    step();
    ia.waddr0 = 3'd5; ia.wdata0 = 48'hABCD;
    step();
    ia.we0 = 0;
    #1;
    nvec++; if (ia.rdata[47:0] !== 48'h0) begin nerr++; $display("FAIL zero_read: got %h expected 0", ia.rdata[47:0]); end
    nvec++; if (ia.rdata[95:48] !== 48'hABCD) begin nerr++; $display("FAIL reg5_read: got %h expected abcd", ia.rdata[95:48]); end
    nvec++; if (ia.pending !== 8'h00) begin nerr++; $display("FAIL zero_pending: got %h expected 00", ia.pending); end
  endtask

  task automatic test_bypass_collision();
    ia.we0 = 1; ia.waddr0 = 3'd3; ia.wdata0 = 48'h111;
    ia.we1 = 1; ia.waddr1 = 3'd3; ia.wdata1 = 48'h222;
    ia.raddr = {3'd0, 3'd3};
    #1;
    nvec++; if (ia.rdata[47:0] !== 48'h222) begin nerr++; $display("FAIL collide_bypass: got %h expected 222", ia.rdata[47:0]); end
    step();
    idle();
    #1;
    nvec++; if (ia.rdata[47:0] !== 48'h222) begin nerr++; $display("FAIL collide_stored: got %h expected 222", ia.rdata[47:0]); end
    ia.we0 = 1; ia.waddr0 = 3'd7; ia.wdata0 = 48'h777;
    ia.raddr = {3'd7, 3'd3};
    #1;
    nvec++; if (ia.rdata[95:48] !== 48'h777) begin nerr++; $display("FAIL port0_bypass: got %h expected 777", ia.rdata[95:48]); end
    step();
    idle();
    step();
    #1;
    nvec++; if (ia.rdata[47:0] !== 48'h222) begin nerr++; $display("FAIL collide_later: got %h expected 222", ia.rdata[47:0]); end
  endtask

  task automatic test_no_bypass();
    ib.we0 = 1; ib.waddr0 = 3'd2; ib.wdata0 = 48'h55;
    ib.raddr = {3'd0, 3'd2};
    #1;
    nvec++; if (ib.rdata[47:0] !== 48'h0) begin nerr++; $display("FAIL nobyp_same: got %h expected 0", ib.rdata[47:0]); end
    step();
    ib.we0 = 0;
    #1;
    nvec++; if (ib.rdata[47:0] !== 48'h55) begin nerr++; $display("FAIL nobyp_next: got %h expected 55", ib.rdata[47:0]); end
  endtask

  task automatic test_scoreboard();
    ia.claim = 1; ia.claim_addr = 3'd4;
    ia.raddr = {3'd4, 3'd0};
    #1;
    nvec++; if (ia.claim_ok !== 1'b1) begin nerr++; $display("FAIL sb_first_ok: got %b expected 1", ia.claim_ok); end
    step();
    #1;
    nvec++; if (ia.pending[4] !== 1'b1) begin nerr++; $display("FAIL sb_pend_set: got %b expected 1", ia.pending[4]); end
    nvec++; if (ia.rbusy !== 2'b10) begin nerr++; $display("FAIL sb_rbusy: got %b expected 10", ia.rbusy); end
    nvec++; if (ia.claim_ok !== 1'b0) begin nerr++; $display("FAIL sb_second_ok: got %b expected 0", ia.claim_ok); end
    step();
    nvec++; if (ia.pending !== 8'h10) begin nerr++; $display("FAIL sb_stall_hold: got %h expected 10", ia.pending); end
    ia.claim = 0;
    ia.we0 = 1; ia.waddr0 = 3'd4; ia.wdata0 = 48'h44;
    #1;
    nvec++; if (ia.rbusy !== 2'b00) begin nerr++; $display("FAIL sb_release_rbusy: got %b expected 00", ia.rbusy); end
    nvec++; if (ia.claim_ok !== 1'b1) begin nerr++; $display("FAIL sb_release_ok: got %b expected 1", ia.claim_ok); end
    step();
    idle();
    #1;
    nvec++; if (ia.pending !== 8'h00) begin nerr++; $display("FAIL sb_pend_clear: got %h expected 00", ia.pending); end
  endtask

  task automatic test_claim_release();
    ia.claim = 1; ia.claim_addr = 3'd6;
    step();
    nvec++; if (ia.pending !== 8'h40) begin nerr++; $display("FAIL cr_pend6: got %h expected 40", ia.pending); end
    ia.we1 = 1; ia.waddr1 = 3'd6; ia.wdata1 = 48'h666;
    #1;
    nvec++; if (ia.claim_ok !== 1'b1) begin nerr++; $display("FAIL cr_ok: got %b expected 1", ia.claim_ok); end
    step();
    idle();
    #1;
    nvec++; if (ia.pending !== 8'h40) begin nerr++; $display("FAIL cr_set_wins: got %h expected 40", ia.pending); end
    ia.claim = 1; ia.claim_addr = 3'd0;
    #1;
    nvec++; if (ia.claim_ok !== 1'b1) begin nerr++; $display("FAIL cr_zero_ok: got %b expected 1", ia.claim_ok); end
    step();
    idle();
    #1;
    nvec++; if (ia.pending !== 8'h40) begin nerr++; $display("FAIL cr_zero_pend: got %h expected 40", ia.pending); end
  endtask

  task automatic test_async_reset();
    ia.claim = 1;
    ia.claim_addr = 3'd4; step();
    ia.claim_addr = 3'd5; step();
    ia.claim_addr = 3'd7; step();
    idle();
    ia.raddr = {3'd5, 3'd3};
    #1;
    nvec++; if (ia.pending !== 8'hF0) begin nerr++; $display("FAIL ar_pend_pre: got %h expected f0", ia.pending); end
    nvec++; if (ia.rdata !== {48'hABCD, 48'h222}) begin nerr++; $display("FAIL ar_rdata_pre: got %h expected abcd/222", ia.rdata); end
    #1;
    rst = 1;
    #1;
    nvec++; if (ia.pending !== 8'h00) begin nerr++; $display("FAIL ar_pend: got %h expected 00", ia.pending); end
    nvec++; if (ia.rdata !== 96'h0) begin nerr++; $display("FAIL ar_rdata: got %h expected 0", ia.rdata); end
    nvec++; if (ia.rbusy !== 2'b00) begin nerr++; $display("FAIL ar_rbusy: got %b expected 00", ia.rbusy); end
    nvec++; if (ia.claim_ok !== 1'b1) begin nerr++; $display("FAIL ar_claim_ok: got %b expected 1", ia.claim_ok); end
    nvec++; if (ib.rdata !== 96'h0) begin nerr++; $display("FAIL ar_rdata_b: got %h expected 0", ib.rdata); end
    #1;
    rst = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_bypass_collision();
    test_no_bypass();
    test_scoreboard();
    test_claim_release();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
